output_buffer: RTL and testbench
================================

OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in 32-bit words; power of two, at least 4.
REQ-002 Parameter AW, default 4, pointer width; equals log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_word  input  33  word from switch crossbar; bit 32 = valid, bits 31:0 = data.
REQ-006 out_data  output  32  word at FIFO head (first-word-fall-through).
REQ-007 out_valid  output  1  out_data holds a word of a fully stored packet.
REQ-008 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-009 out_sop  output  1  out_data is a packet header; qualified by out_valid.
REQ-010 out_eop  output  1  out_data is the last word of a packet; qualified by out_valid.
REQ-011 pkt_count  output  AW+1  number of complete packets held.
REQ-012 drop_count  output  8  packets discarded; saturates at 255.

Function
REQ-013 Packet format: header word followed by LEN payload words; header fields are [31:24] dest, [23:8] LEN, [7:0] source.
REQ-014 Input FSM states: IDLE, STORE, DROP.
REQ-015 IDLE, valid word: treat as header; compute free = DEPTH - occupancy at start of cycle, ignoring any same-cycle pop.
REQ-016 Accept when LEN+1 <= free: write header; go to STORE if LEN > 0, else packet is complete and FSM stays in IDLE.
REQ-017 Reject otherwise, including any LEN > DEPTH-1: write nothing, increment drop_count (saturating), go to DROP if LEN > 0.
REQ-018 STORE: each valid word is written and decrements the remaining count; the write of the final word completes the packet and returns the FSM to IDLE.
REQ-019 DROP: each valid word is discarded and decrements the remaining count; the final word returns the FSM to IDLE.
REQ-020 Invalid cycles (bit 32 = 0) in any input state change nothing.
REQ-021 Packet completion increments pkt_count at that clock edge; out_valid can rise no earlier than the following cycle (store-and-forward latency of 1 cycle after the last write).
REQ-022 Output FSM states: IDLE, SEND.
REQ-023 Output IDLE: out_valid = (pkt_count > 0); out_sop = 1; the header's LEN loads the remaining-word count on transfer.
REQ-024 On transfer of a header with LEN = 0, out_eop = 1; pkt_count decrements; FSM stays in IDLE.
REQ-025 On transfer of a header with LEN > 0, FSM goes to SEND.
REQ-026 SEND: out_valid = 1; out_sop = 0; out_eop = 1 on the last payload word.
REQ-027 Transfer of the eop word decrements pkt_count and returns the output FSM to IDLE.
REQ-028 Simultaneous packet completion and eop transfer leaves pkt_count unchanged.
REQ-029 Simultaneous write and read in the same cycle leaves occupancy unchanged.
REQ-030 Pointers wrap modulo DEPTH.
REQ-031 Occupancy never exceeds DEPTH, because admission is checked per packet.
REQ-032 out_data is undefined when out_valid is low.

Reset
REQ-033 Under rst the following are cleared, with rst taking precedence over all other inputs:
- read and write pointers, occupancy, pkt_count and drop_count cleared to 0;
- both FSMs set to IDLE;
- out_valid, out_sop and out_eop driven 0.
REQ-034 Reset mid-packet discards all stored and partial packets; the first valid word after reset is treated as a header.

Verification
REQ-035 Basic packet, out_ready = 1: header 0x03000501 then 32, 10, 7, 128, 200 on consecutive cycles -> out_valid rises 1 cycle after the word 200 is written; outputs 0x03000501 (sop), 32, 10, 7, 128, 200 (eop); pkt_count goes 1 -> 0.
REQ-036 Backpressure: same packet, out_ready toggling 1/0 -> every word is delivered exactly once, in order; out_valid never drops inside the packet.
REQ-037 Oversize: header 0x01001402 (LEN 20) plus 20 words -> nothing is output; drop_count = 1; the next header 0x01000302 with 3 payload words is stored and output normally.
REQ-038 Full buffer: two LEN = 6 packets stored with out_ready = 0 (occupancy 14); a third header with LEN 3 -> dropped, drop_count increments; set out_ready = 1 -> the two stored packets are output intact.
REQ-039 Zero length and overlap: header 0x02000001 -> a single word with both sop and eop; a second packet completing in the same cycle as an eop transfer -> pkt_count is unchanged that cycle.
REQ-040 Reset mid-packet: rst asserted after the header plus 2 of 5 payload words -> out_valid = 0 and pkt_count = 0; a fresh packet after reset is output correctly.

Source files
------------

// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - store-and-forward packet output FIFO with per-packet admission
module output_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [32:0]   in_word,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic [AW:0]   pkt_count,
  output logic [7:0]    drop_count
);

  typedef enum logic [1:0] {IN_IDLE, IN_STORE, IN_DROP} in_state_t;
  typedef enum logic       {OUT_IDLE, OUT_SEND} out_state_t;

  logic [31:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic [AW:0]   r_pkt_cnt;
  logic [7:0]    r_drop_cnt;
  in_state_t     r_in_state;
  logic [15:0]   r_in_rem;
  out_state_t    r_out_state;
  logic [15:0]   r_out_rem;

  in_state_t     w_in_state_nxt;
  logic [15:0]   w_in_rem_nxt;
  logic          w_wr_en;
  logic          w_pkt_done;
  logic          w_drop;
  logic [15:0]   w_len;
  logic [16:0]   w_free;
  logic [16:0]   w_need;
  out_state_t    w_out_state_nxt;
  logic [15:0]   w_out_rem_nxt;
  logic          w_rd_en;
  logic          w_pkt_sent;
  logic [15:0]   w_head_len;

  assign w_len      = in_word[23:8];
  // Free space ignores a same-cycle pop so admission never depends on downstream timing.
  assign w_free     = 17'(DEPTH) - 17'(r_occ);
  assign w_need     = {1'b0, w_len} + 17'd1;
  assign w_head_len = r_mem[r_rd_ptr][23:8];
  assign out_data   = r_mem[r_rd_ptr];
  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop_cnt;

  // Input FSM: admit whole packets only, otherwise skip all of their words.
  always_comb begin
    w_in_state_nxt = r_in_state;
    w_in_rem_nxt   = r_in_rem;
    w_wr_en        = 1'b0;
    w_pkt_done     = 1'b0;
    w_drop         = 1'b0;
    if (in_word[32]) begin
      case (r_in_state)
        IN_IDLE: begin
          if (w_need <= w_free) begin
            w_wr_en = 1'b1;
            if (w_len == 16'd0) begin
              w_pkt_done = 1'b1;
            end else begin
              w_in_state_nxt = IN_STORE;
              w_in_rem_nxt   = w_len;
            end
          end else begin
            w_drop = 1'b1;
            if (w_len != 16'd0) begin
              w_in_state_nxt = IN_DROP;
              w_in_rem_nxt   = w_len;
            end
          end
        end
        IN_STORE: begin
          w_wr_en      = 1'b1;
          w_in_rem_nxt = r_in_rem - 16'd1;
          if (r_in_rem == 16'd1) begin
            w_pkt_done     = 1'b1;
            w_in_state_nxt = IN_IDLE;
          end
        end
        IN_DROP: begin
          w_in_rem_nxt = r_in_rem - 16'd1;
          if (r_in_rem == 16'd1) begin
            w_in_state_nxt = IN_IDLE;
          end
        end
        default: w_in_state_nxt = IN_IDLE;
      endcase
    end
  end

  // Output FSM: present the head word once a complete packet is held, stream it to eop.
  always_comb begin
    out_valid       = 1'b0;
    out_sop         = 1'b0;
    out_eop         = 1'b0;
    w_out_state_nxt = r_out_state;
    w_out_rem_nxt   = r_out_rem;
    w_rd_en         = 1'b0;
    w_pkt_sent      = 1'b0;
    if (!rst) begin
      case (r_out_state)
        OUT_IDLE: begin
          out_valid = (r_pkt_cnt != '0);
          out_sop   = out_valid;
          out_eop   = out_valid && (w_head_len == 16'd0);
          if (out_valid && out_ready) begin
            w_rd_en = 1'b1;
            if (w_head_len == 16'd0) begin
              w_pkt_sent = 1'b1;
            end else begin
              w_out_state_nxt = OUT_SEND;
              w_out_rem_nxt   = w_head_len;
            end
          end
        end
        OUT_SEND: begin
          out_valid = 1'b1;
          out_eop   = (r_out_rem == 16'd1);
          if (out_ready) begin
            w_rd_en       = 1'b1;
            w_out_rem_nxt = r_out_rem - 16'd1;
            if (r_out_rem == 16'd1) begin
              w_pkt_sent      = 1'b1;
              w_out_state_nxt = OUT_IDLE;
            end
          end
        end
        default: w_out_state_nxt = OUT_IDLE;
      endcase
    end
  end

  // Packet storage; contents need no reset because pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= in_word[31:0];
    end
  end

  // Pointers, occupancy, counters and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_in_state  <= IN_IDLE;
      r_in_rem    <= '0;
      r_out_state <= OUT_IDLE;
      r_out_rem   <= '0;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_in_rem    <= w_in_rem_nxt;
      r_out_state <= w_out_state_nxt;
      r_out_rem   <= w_out_rem_nxt;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
      case ({w_pkt_done, w_pkt_sent})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + (AW+1)'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - (AW+1)'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - scoreboard testbench for output_buffer
module tb_output_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [32:0]   in_word;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [AW:0]   pkt_count;
  logic [7:0]    drop_count;

  int          errors = 0;
  int          checks = 0;
  logic [33:0] sb [$];
  logic [31:0] pl_q [$];
  logic [33:0] exp_w;
  bit          toggle_en = 1'b0;
  bit          in_pkt = 1'b0;

  always #5 clk = ~clk;

  output_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  // Output monitor: every transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0;
    end else begin
      if (in_pkt) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_gap: out_valid=%0b required 1", out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h sop=%0b eop=%0b required no transfer", out_data, out_sop, out_eop);
        end else begin
          exp_w = sb.pop_front();
          if ({out_sop, out_eop, out_data} !== exp_w) begin
            errors++;
            $display("FAIL out_word: got sop=%0b eop=%0b data=%h required sop=%0b eop=%0b data=%h",
                     out_sop, out_eop, out_data, exp_w[33], exp_w[32], exp_w[31:0]);
          end
        end
        if (out_eop) in_pkt = 1'b0;
        else if (out_sop) in_pkt = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) out_ready = ~out_ready;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input bit keep);
    int n;
    n = pl_q.size();
    if (keep) sb.push_back({1'b1, (n == 0), hdr});
    in_word = {1'b1, hdr};
    tick();
    for (int i = 0; i < n; i++) begin
      if (keep) sb.push_back({1'b0, (i == n - 1), pl_q[i]});
      in_word = {1'b1, pl_q[i]};
      tick();
    end
    in_word = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && pkt_count == 0 && out_valid === 1'b0) break;
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: words left=%0d required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL drain_pkt_count: got %0d required 0", pkt_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_word = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_sop, out_eop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {out_valid, out_sop, out_eop});
    end
    checks++;
    if (pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_pkt_count: got %0d required 0", pkt_count);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_count: got %0d required 0", drop_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %0b required 0", out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w [6];
    w = '{32'h03000501, 32'd32, 32'd10, 32'd7, 32'd128, 32'd200};
    toggle_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({(i == 0), 1'b0, w[i]});
      in_word = {1'b1, w[i]};
      tick();
    end
    sb.push_back({1'b0, 1'b1, w[5]});
    in_word = {1'b1, w[5]};
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %0b required 0", out_valid);
    end
    tick();
    in_word = '0;
    checks++;
    if ({out_valid, out_sop} !== 2'b11) begin
      errors++;
      $display("FAIL basic_latency: got valid,sop=%b required 11", {out_valid, out_sop});
    end
    checks++;
    if (pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL basic_pkt_count: got %0d required 1", pkt_count);
    end
    wait_drain(50);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    toggle_en = 1'b1;
    pl_q = {32'd32, 32'd10, 32'd7, 32'd128, 32'd200};
    send_pkt(32'h03000501, 1'b1);
    wait_drain(60);
    toggle_en = 1'b0;
  endtask

  task automatic test_oversize();
    out_ready = 1'b1;
    pl_q.delete();
    for (int i = 0; i < 20; i++) pl_q.push_back(32'd100 + 32'(i));
    send_pkt(32'h01001402, 1'b0);
    tick();
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL oversize_drop: got %0d required 1", drop_count);
    end
    checks++;
    if ({out_valid, pkt_count} !== 6'd0) begin
      errors++;
      $display("FAIL oversize_stored: got valid=%0b pkt_count=%0d required 0 0", out_valid, pkt_count);
    end
    pl_q = {32'hA1, 32'hA2, 32'hA3};
    send_pkt(32'h01000302, 1'b1);
    wait_drain(40);
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL oversize_next_drop: got %0d required 1", drop_count);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    pl_q = {32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
    send_pkt(32'h04000601, 1'b1);
    pl_q = {32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26};
    send_pkt(32'h04000602, 1'b1);
    checks++;
    if (pkt_count !== 5'd2) begin
      errors++;
      $display("FAIL full_pkt_count: got %0d required 2", pkt_count);
    end
    pl_q = {32'h31, 32'h32, 32'h33};
    send_pkt(32'h04000302, 1'b0);
    checks++;
    if (drop_count !== 8'd2) begin
      errors++;
      $display("FAIL full_drop: got %0d required 2", drop_count);
    end
    checks++;
    if (pkt_count !== 5'd2) begin
      errors++;
      $display("FAIL full_pkt_after_drop: got %0d required 2", pkt_count);
    end
    out_ready = 1'b1;
    wait_drain(60);
  endtask

  task automatic test_zero_len_overlap();
    out_ready = 1'b1;
    pl_q.delete();
    send_pkt(32'h02000001, 1'b1);
    checks++;
    if ({out_valid, out_sop, out_eop} !== 3'b111) begin
      errors++;
      $display("FAIL zero_len_flags: got %b required 111", {out_valid, out_sop, out_eop});
    end
    wait_drain(20);
    out_ready = 1'b0;
    pl_q = {32'h55};
    send_pkt(32'h0A000103, 1'b1);
    out_ready = 1'b1;
    sb.push_back({1'b1, 1'b0, 32'h0B000104});
    in_word = {1'b1, 32'h0B000104};
    tick();
    sb.push_back({1'b0, 1'b1, 32'h66});
    in_word = {1'b1, 32'h66};
    checks++;
    if ({out_valid, out_eop} !== 2'b11) begin
      errors++;
      $display("FAIL overlap_eop: got valid,eop=%b required 11", {out_valid, out_eop});
    end
    tick();
    in_word = '0;
    checks++;
    if (pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL overlap_pkt_count: got %0d required 1", pkt_count);
    end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_word = {1'b1, 32'h03000501};
    tick();
    in_word = {1'b1, 32'd1};
    tick();
    in_word = {1'b1, 32'd2};
    tick();
    in_word = '0;
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, pkt_count} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got valid=%0b pkt_count=%0d required 0 0", out_valid, pkt_count);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_drop: got %0d required 0", drop_count);
    end
    rst = 1'b0;
    tick();
    pl_q = {32'hC1, 32'hC2, 32'hC3};
    send_pkt(32'h05000309, 1'b1);
    wait_drain(30);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_oversize();
    test_full();
    test_zero_len_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
